ram_sweep_sp: RTL



---
 rtl/ram_pkg.sv | 22 ++
 rtl/ram_sweep_fsm.sv | 57 +++++
 rtl/ram_sweep_sp.sv | 126 ++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared state type, latency/format constants and parity helper for ram_sweep_sp
package ram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  localparam logic FMT_RAW  = 1'b1;
  localparam logic FMT_OFFS = 1'b0;

  localparam int PAR_MAX_W = 64;

  // Even parity bit: the XOR of the data word and this bit is zero.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/ram_sweep_fsm.sv
// rtl/ram_sweep_fsm.sv - clear-sweep controller: state, sweep counter, busy and sweep write strobe
module ram_sweep_fsm
  import ram_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter int INIT_CLR = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              busy,
  output logic              idle,
  output logic              sweep_we,
  output logic [ADDR_W-1:0] sweep_addr
);

  localparam state_t            RST_STATE = (INIT_CLR != 0) ? SWEEP : IDLE;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST_STATE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The counter wraps to 0 on its own after the last address.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy      = 1'b0;
    idle      = 1'b0;
    sweep_we  = 1'b0;
    unique case (state)
      IDLE: begin
        idle = 1'b1;
        if (clr_req) state_nxt = SWEEP;
      end
      SWEEP: begin
        busy     = 1'b1;
        sweep_we = 1'b1;
        cnt_nxt  = cnt + 1'b1;
        if (cnt == LAST_ADDR) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign sweep_addr = cnt;

endmodule

// File: rtl/ram_sweep_sp.sv
// rtl/ram_sweep_sp.sv - single-port RAM with clear sweep, registered read, format stage
// Optional even-parity protection and parity_err port with RAM_PARITY_EN.
module ram_sweep_sp
  import ram_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 6,
  parameter int                RD_LAT    = 1,
  parameter logic [DATA_W-1:0] CLR_VALUE = '0,
  parameter int                INIT_CLR  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fmt_sel,
  input  logic              clr_req,
  output logic              busy,
  output logic              rd_valid,
  output logic [DATA_W-1:0] data_out
`ifdef RAM_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int N_STAGE = (RD_LAT >= RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT_MIN;
`ifdef RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  logic [MEM_W-1:0]  mem [DEPTH];

  logic              idle, sweep_we;
  logic [ADDR_W-1:0] sweep_addr;
  logic              we, rd_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  s1_q, fin_q;
  logic              s1_v, fin_v;
  logic [DATA_W-1:0] rd_data;

  ram_sweep_fsm #(
    .ADDR_W   (ADDR_W),
    .INIT_CLR (INIT_CLR)
  ) u_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_req    (clr_req),
    .busy       (busy),
    .idle       (idle),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr)
  );

  // A clear request in IDLE takes priority over a coincident access.
  always_comb begin
    we      = sweep_we | (idle & cs & wr & ~clr_req);
    rd_en   = idle & cs & ~wr & ~clr_req;
    wr_addr = sweep_we ? sweep_addr : addr;
    wr_data = sweep_we ? CLR_VALUE : data_in;
`ifdef RAM_PARITY_EN
    wr_word = {even_parity(PAR_MAX_W'(wr_data)), wr_data};
`else
    wr_word = wr_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s1_v <= 1'b0;
    end else begin
      s1_v <= rd_en;
      if (rd_en) s1_q <= mem[addr];
    end
  end

  generate
    if (N_STAGE == 2) begin : g_stage2
      logic [MEM_W-1:0] s2_q;
      logic             s2_v;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_q <= '0;
          s2_v <= 1'b0;
        end else begin
          s2_v <= s1_v;
          if (s1_v) s2_q <= s1_q;
        end
      end
      assign fin_q = s2_q;
      assign fin_v = s2_v;
    end else begin : g_stage1
      assign fin_q = s1_q;
      assign fin_v = s1_v;
    end
  endgenerate

  assign rd_valid = fin_v;
  assign rd_data  = fin_q[DATA_W-1:0];

`ifdef RAM_PARITY_EN
  assign parity_err = fin_v & (even_parity(PAR_MAX_W'(rd_data)) != fin_q[DATA_W]);
`endif

  always_comb begin
    data_out = rd_data;
    unique case (fmt_sel)
      FMT_RAW:  data_out = rd_data;
      FMT_OFFS: data_out = {~rd_data[DATA_W-1], rd_data[DATA_W-2:0]};
      default:  data_out = rd_data;
    endcase
  end

endmodule
